// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: IF-stage PC generator and instruction-fetch sequencer.
//
// Issues one instruction-memory request at a time and captures the returned
// word into a one-entry IF/ID buffer (validF/instrF/pcF). It applies the
// redirect computed in ID, always fetching and delivering the single MIPS
// branch delay slot first. An exception/ERET flush overrides everything, and
// any fetch still in flight when the flush lands is discarded.
//
// Optional build macro: FETCH_ADEL_EN
//   When defined, a misaligned fetch address is not sent to memory. Instead an
//   address-error marker is delivered (excF=1, instrF=0, pcF=bad address), and
//   fetch parks until the next exc_flush.
//   When undefined, excF is tied 0 and addresses are issued as-is.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   stallF                 IF/ID cannot accept; the buffer is held
//   redirD, redir_targetD  one-cycle redirect pulse from ID, and its target
//   pcD                    PC of the redirecting instruction in ID
//   exc_flush, exc_pc      exception/ERET flush and its destination
//   inst_req, inst_addr    memory request valid and address
//   inst_addr_ok           request accepted this cycle
//   inst_data_ok           read data returned this cycle
//   inst_rdata             read data
//   validF, instrF, pcF    IF/ID buffer: valid flag, instruction, and its PC
//   excF                   address-error flag for the buffered entry
module fetch_pc_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            stallF,
    input  logic            redirD,
    input  logic [XLEN-1:0] redir_targetD,
    input  logic [XLEN-1:0] pcD,
    input  logic            exc_flush,
    input  logic [XLEN-1:0] exc_pc,
    output logic            inst_req,
    output logic [XLEN-1:0] inst_addr,
    input  logic            inst_addr_ok,
    input  logic            inst_data_ok,
    input  logic [XLEN-1:0] inst_rdata,
    output logic            validF,
    output logic [XLEN-1:0] instrF,
    output logic [XLEN-1:0] pcF,
    output logic            excF
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} stateT;

    stateT           state, stateNxt;
    logic [XLEN-1:0] pcNxt;        // next sequential fetch address
    logic            pend;         // redirect target not yet issued
    logic [XLEN-1:0] pendTarget;
    logic            dsIssued;     // delay slot of the pending branch already sent
    logic [XLEN-1:0] reqAddr;      // address of the fetch in flight

    logic [XLEN-1:0] issueAddr;
    logic [XLEN-1:0] pcAfter;
    logic            bufFree;
    logic            consume;
    logic            misalign;
    logic            reqRaw;
    logic            accept;
    logic            fill;
    logic            adelLoad;

`ifdef FETCH_ADEL_EN
    logic            adelHeld;     // address-error entry already delivered
`endif

    // The delay slot goes out before the target. Only after it has been
    // issued does the pending target replace the sequential PC.
    assign issueAddr = (pend && dsIssued) ? pendTarget : pcNxt;
    assign bufFree   = !validF || !stallF;
    assign consume   = validF && !stallF;
    assign inst_addr = issueAddr;
    assign inst_req  = reqRaw && resetn;
    assign accept    = inst_req && inst_addr_ok;

    // The sequential PC after this edge. Used to decide whether the delay slot
    // is already out, which also covers the slot being accepted in the same
    // cycle as the redirect.
    assign pcAfter   = accept ? issueAddr + XLEN'(4) : pcNxt;

`ifdef FETCH_ADEL_EN
    assign misalign  = issueAddr[1:0] != 2'b00;
`else
    assign misalign  = 1'b0;
`endif

    always_comb begin
        stateNxt = state;
        reqRaw   = 1'b0;
        fill     = 1'b0;
        adelLoad = 1'b0;
        case (state)
            S_REQ: begin
                if (bufFree) begin
                    if (misalign) begin
`ifdef FETCH_ADEL_EN
                        adelLoad = !adelHeld;
`endif
                    end else begin
                        reqRaw = 1'b1;
                    end
                end
                if (accept) stateNxt = S_WAIT;
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    fill     = 1'b1;
                    stateNxt = S_REQ;
                end
            end
            S_DROP: begin
                if (inst_data_ok) stateNxt = S_REQ;
            end
            default: stateNxt = S_REQ;
        endcase
        // Flush: nothing is captured, and a fetch still in flight (just
        // accepted, or not yet returned) must drain through S_DROP.
        if (exc_flush) begin
            fill     = 1'b0;
            adelLoad = 1'b0;
            if (state == S_REQ)
                stateNxt = accept ? S_DROP : S_REQ;
            else
                stateNxt = inst_data_ok ? S_REQ : S_DROP;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_REQ;
            pcNxt      <= RESET_PC;
            pend       <= 1'b0;
            pendTarget <= '0;
            dsIssued   <= 1'b0;
            reqAddr    <= '0;
            validF     <= 1'b0;
            instrF     <= '0;
            pcF        <= '0;
        end else begin
            state <= stateNxt;
            if (accept) reqAddr <= issueAddr;

            if (exc_flush) begin
                pcNxt    <= exc_pc;
                pend     <= 1'b0;
                dsIssued <= 1'b0;
            end else begin
                if (accept) pcNxt <= issueAddr + XLEN'(4);
                if (redirD) begin
                    pend       <= 1'b1;
                    pendTarget <= redir_targetD;
                    dsIssued   <= (pcAfter != pcD + XLEN'(4));
                end else if (accept && pend) begin
                    if (dsIssued) pend     <= 1'b0;   // target went out
                    else          dsIssued <= 1'b1;   // delay slot went out
                end
            end

            // A refill on the same edge as consumption keeps validF high.
            if (exc_flush) begin
                validF <= 1'b0;
            end else if (fill) begin
                validF <= 1'b1;
                instrF <= inst_rdata;
                pcF    <= reqAddr;
            end else if (adelLoad) begin
                validF <= 1'b1;
                instrF <= '0;
                pcF    <= issueAddr;
            end else if (consume) begin
                validF <= 1'b0;
            end
        end
    end

`ifdef FETCH_ADEL_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            excF     <= 1'b0;
            adelHeld <= 1'b0;
        end else begin
            if (exc_flush) begin
                excF     <= 1'b0;
                adelHeld <= 1'b0;
            end else if (fill) begin
                excF <= 1'b0;
            end else if (adelLoad) begin
                excF     <= 1'b1;
                adelHeld <= 1'b1;
            end else if (consume) begin
                excF <= 1'b0;
            end
        end
    end
`else
    assign excF = 1'b0;
`endif

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- IF-stage PC generator and instruction-fetch sequencer.
- Sits directly upstream of the ID-stage branch/jump decoder. It issues instruction-memory requests, buffers the returned instruction for IF/ID, and applies the branch/jump redirect that ID computes.
- Honours the MIPS single branch delay slot, hazard stalls and exception flush.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- XLEN, 32, address/data width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- stallF  in  1  hazard unit: IF/ID may not accept (buffer held)
- redirD  in  1  one-cycle pulse: ID has a taken branch, J/JAL or JR/JALR
- redir_targetD  in  32  redirect target; ID has already selected branch/jump/register target
- pcD  in  32  PC of the redirecting instruction in ID
- exc_flush  in  1  exception/ERET flush, highest priority
- exc_pc  in  32  flush destination
- inst_req  out  1  memory request valid
- inst_addr  out  32  request address
- inst_addr_ok  in  1  address accepted this cycle
- inst_data_ok  in  1  read data returned this cycle
- inst_rdata  in  32  read data
- validF  out  1  instrF/pcF hold a fetched instruction
- instrF  out  32  fetched instruction
- pcF  out  32  its PC
- excF  out  1  address-error flag (see Optional Feature)

Behaviour:
- Reset (resetn=0 at a clk edge):
  - pc_nxt=RESET_PC, state=S_REQ, validF=0, instrF=0, pcF=0, excF=0, pending redirect cleared.
  - inst_req forced 0 while resetn=0.
- Interface rule: at most one outstanding fetch.
- Consumption: buffer is consumed on a cycle with validF=1 && stallF=0.
- FSM:
  - S_REQ:
    - Entry condition: buffer empty, or being consumed this cycle.
    - inst_req=1, inst_addr=issue_addr.
    - On inst_addr_ok: pc_nxt=issue_addr+4, go to S_WAIT.
    - If the buffer is full and not consumed, inst_req=0 (stay).
  - S_WAIT:
    - inst_req=0.
    - On inst_data_ok: instrF<=inst_rdata, pcF<=address issued, validF<=1, go to S_REQ.
  - S_DROP:
    - inst_req=0.
    - On inst_data_ok: discard data, validF unchanged (0), go to S_REQ.
- Buffer: validF clears on consumption unless refilled the same edge; refill and consumption in the same cycle are both allowed.
- Latency: request accepted at cycle N with data_ok at N+k gives validF=1 at N+k+1.
- Redirect / delay slot:
  - On redirD, latch pend=1, pend_target=redir_targetD, ds_issued=(pc_nxt != pcD+4).
  - issue_addr = pend && ds_issued ? pend_target : pc_nxt.
  - When an address is accepted while pend && !ds_issued, that address is the delay slot: set ds_issued=1.
  - When the target address is accepted, clear pend.
  - The delay-slot instruction is always fetched and delivered; it is never squashed by a redirect.
  - redirD while pend=1: the new value overwrites the pending one. A new redirect cannot legally arrive before the previous target is issued; the bench checks this with an assertion.
- exc_flush (any state):
  - pc_nxt=exc_pc, pend=0, validF=0.
  - From S_WAIT with no data_ok this cycle, go to S_DROP.
  - If inst_addr_ok in S_REQ the same cycle, go to S_DROP.
  - If inst_data_ok in S_WAIT the same cycle, data is dropped and the next state is S_REQ.
  - Otherwise go to S_REQ.
- Simultaneous exc_flush and redirD: flush wins, redirect ignored.
- Reset mid-transaction: state returns to S_REQ. The memory side must likewise be reset; any stale data_ok after reset is undefined.
- Arithmetic: PC increments are 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

Optional Feature:
- Macro: FETCH_ADEL_EN.
- Defined:
  - If issue_addr[1:0]!=0, no memory request is issued.
  - In S_REQ the block directly loads validF=1, instrF=32'h0, pcF=issue_addr, excF=1, once the buffer is free.
  - The FSM stays in S_REQ and holds pc_nxt until exc_flush.
- Undefined: excF tied 0; the address is issued unchanged.

Test Plan:
- Reset then single-cycle memory (addr_ok in S_REQ, data_ok next cycle), stallF=0 -> inst_addr sequence BFC00000, BFC00004, BFC00008; pcF follows two cycles later.
- stallF=1 for 3 cycles with validF=1 -> instrF/pcF stable, inst_req=0; release -> next address issued the same cycle.
- Branch at BFC00010 redirects to BFC00100:
  - Delay slot BFC00014 not yet issued -> issue order BFC00014 then BFC00100.
  - Delay slot already issued -> BFC00100 next.
  - Delay slot delivered with validF=1 in both cases.
- exc_flush in S_WAIT with data_ok 2 cycles later, exc_pc=BFC00380 -> returned word discarded, validF stays 0, next inst_addr=BFC00380.
- exc_flush and redirD in the same cycle -> next address is exc_pc, pend clear.
- FETCH_ADEL_EN: redirect to 0x80000002 -> no inst_req to it, validF=1, excF=1, pcF=0x80000002, instrF=0.
